controle_multiciclo: RTL
========================

# controle_multiciclo

Multi-cycle control FSM that sequences the shared MIPS datapath: one ALU, one unified memory, one register file, one PC. Instead of the single-cycle decoder's per-instruction control word, it steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states and drives per-cycle datapath enables. It stalls on a memory ready handshake, counts retired instructions, and halts on unsupported opcodes.

## Interface
- COUNT_W, 32, width of retired-instruction counter
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  6  Instruction[31:26] from the instruction register
- mem_ready  in  1  memory completes the current read/write this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA  out  1 each  datapath enables/selects
- ALUSrcB  out  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
- PCSource  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump address
- ALUOp  out  2  to alucontrol: 00 add, 01 sub, 10 funct field
- state_o  out  4  current state encoding (debug)
- instr_count  out  COUNT_W  retired instructions, wraps modulo 2^COUNT_W
- illegal_op  out  1  sticky, set on entry to HALT

## Operation
- States and encodings: INIT=0, FETCH=1, DECODE=2, MEMADR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12, HALT=13. Encodings 14 and 15 go to INIT.
- INIT -> FETCH unconditionally.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite equal mem_ready (Mealy-gated). Stay while !mem_ready; else -> DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Dispatch on opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 (addi) -> ADDIEX
  - any other -> HALT
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: MemRead=1, IorD=1. Wait on mem_ready, then -> MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. -> FETCH.
- MEMWRITE: MemWrite=1, IorD=1. Wait on mem_ready, then -> FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. -> ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. -> FETCH.
- JUMP: PCWrite=1, PCSource=10. -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. -> FETCH.
- HALT: all datapath outputs 0, illegal_op=1. Remains in HALT until reset.
- Any output not listed for a state is 0.
- instr_count increments on the cycle leaving a final state toward FETCH: MEMWB, MEMWRITE with mem_ready, ALUWB, BRANCH, JUMP, ADDIWB. It does not increment on HALT.

## Timing
- Reset (async assert, synchronous release): state=INIT, instr_count=0, illegal_op=0, every datapath output 0. Outputs remain 0 for the INIT cycle.
- First FETCH occurs in the 2nd cycle after reset_n rises.
- Cycles per instruction with mem_ready held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. Control outputs are held stable during the stall, with PCWrite and IRWrite held at 0.
- Outputs are decoded from the registered state, except IRWrite/PCWrite in FETCH, which also depend on mem_ready. There are no combinational paths from opcode to outputs.
- opcode is sampled only in DECODE, and IR must be stable from DECODE until FETCH.
- reset_n asserted mid-instruction aborts it immediately. No counter update occurs for the aborted instruction.

## Structure
- Shared package mips_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - state enum/localparams
  - ALUSrcB, PCSource and ALUOp encodings
- Single module, no sub-modules. Organised as a state register, a next-state block and an output decode block; the counter is an inline always block.

## Test plan
- Reset held 3 cycles, then released with mem_ready=1 and opcode=100011 -> state_o sequence 0,1,2,3,4,5,1. RegWrite=1 and MemtoReg=1 only in state 5. instr_count=1 after the 6th cycle.
- sw with mem_ready=0 for 3 cycles in MEMWRITE -> MemWrite=1 and IorD=1 held for 4 cycles, then FETCH. instr_count increments exactly once.
- Sequence R-type, addi, beq, j -> lengths 4, 4, 3, 3 cycles. Check ALUOp=10 in EXEC, ALUOp=01 with PCWriteCond=1 in BRANCH, PCSource=10 in JUMP. instr_count=4.
- FETCH stall with mem_ready=0 for 5 cycles -> PCWrite=0 and IRWrite=0 throughout; both go to 1 in the same cycle mem_ready rises.
- opcode=111111 in DECODE -> HALT (13), illegal_op=1, all enables 0 for 20+ cycles. Reset then returns state_o=0 and illegal_op=0.
- reset_n pulsed low while in MEMREAD -> outputs go to 0 asynchronously, instr_count=0, and restart from INIT.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states
// and the datapath mux/ALU select codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    StInit     = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAdr   = 4'd3,
    StMemRead  = 4'd4,
    StMemWb    = 4'd5,
    StMemWrite = 4'd6,
    StExec     = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJump     = 4'd10,
    StAddiEx   = 4'd11,
    StAddiWb   = 4'd12,
    StHalt     = 4'd13
  } state_e;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

endpackage

// File: rtl/controle_multiciclo.sv
// Multi-cycle MIPS control FSM: sequences the shared datapath per state,
// stalls on mem_ready, counts retired instructions and halts on bad opcodes.
module controle_multiciclo
  import mips_pkg::*;
#(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUOp,
  output logic [3:0]         state_o,
  output logic [COUNT_W-1:0] instr_count,
  output logic               illegal_op
);

  state_e               r_state;
  state_e               w_next;
  logic                 r_is_store;
  logic                 w_is_store_d;
  logic                 w_retire;
  logic [COUNT_W-1:0]   r_count;
  logic                 r_illegal;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StInit;
      r_is_store <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_is_store <= w_is_store_d;
      if (w_next == StHalt) r_illegal <= 1'b1;
    end
  end

  // Opcode is only looked at in DECODE; the lw/sw split is latched here so
  // MEMADR never depends on the IR.
  always_comb begin
    w_next       = r_state;
    w_is_store_d = r_is_store;
    case (r_state)
      StInit:     w_next = StFetch;
      StFetch:    if (mem_ready) w_next = StDecode;
      StDecode: begin
        case (opcode)
          OP_LW: begin
            w_next       = StMemAdr;
            w_is_store_d = 1'b0;
          end
          OP_SW: begin
            w_next       = StMemAdr;
            w_is_store_d = 1'b1;
          end
          OP_RTYPE: w_next = StExec;
          OP_BEQ:   w_next = StBranch;
          OP_J:     w_next = StJump;
          OP_ADDI:  w_next = StAddiEx;
          default:  w_next = StHalt;
        endcase
      end
      StMemAdr:   w_next = r_is_store ? StMemWrite : StMemRead;
      StMemRead:  if (mem_ready) w_next = StMemWb;
      StMemWb:    w_next = StFetch;
      StMemWrite: if (mem_ready) w_next = StFetch;
      StExec:     w_next = StAluWb;
      StAluWb:    w_next = StFetch;
      StBranch:   w_next = StFetch;
      StJump:     w_next = StFetch;
      StAddiEx:   w_next = StAddiWb;
      StAddiWb:   w_next = StFetch;
      StHalt:     w_next = StHalt;
      default:    w_next = StInit;
    endcase
  end

  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      StMemWb, StAluWb, StBranch, StJump, StAddiWb: w_retire = 1'b1;
      StMemWrite:                                   w_retire = mem_ready;
      default:                                      w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (w_retire) begin
      r_count <= r_count + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SrcBReg;
    PCSource    = PcAlu;
    ALUOp       = AluAdd;
    case (r_state)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = SrcBFour;
        // IR and PC latch only in the cycle the memory actually delivers.
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      StDecode: ALUSrcB = SrcBImmSh;
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SrcBImm;
      end
      StMemRead: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      StMemWrite: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      StExec: begin
        ALUSrcA = 1'b1;
        ALUOp   = AluFunct;
      end
      StAluWb: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      StBranch: begin
        ALUSrcA     = 1'b1;
        ALUOp       = AluSub;
        PCWriteCond = 1'b1;
        PCSource    = PcAluOut;
      end
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = PcJump;
      end
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SrcBImm;
      end
      StAddiWb: RegWrite = 1'b1;
      default: ;
    endcase
  end

  assign state_o     = r_state;
  assign instr_count = r_count;
  assign illegal_op  = r_illegal;

endmodule
